// File: rtl/alu_wide_seq.sv
// Sequencer that runs a 16-bit ADD/SUB as two passes through an external 8-bit ALU,
// low byte first, chaining the low-byte carry/borrow into the high-byte opcode.
module alu_wide_seq #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [15:0]   r_a;
    logic [15:0]   r_b;
    logic          r_op;
    logic          r_c_lo;
    logic          r_z_lo;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_res_lo;
    logic [15:0]   r_rsp_result;
    logic [3:0]    r_rsp_flags;
    logic          w_pass_done;

    assign w_pass_done = (r_cnt == {CW{1'b0}});

    // Control FSM: request capture, two timed ALU passes, response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= 16'd0;
            r_b          <= 16'd0;
            r_op         <= 1'b0;
            r_c_lo       <= 1'b0;
            r_z_lo       <= 1'b0;
            r_cnt        <= {CW{1'b0}};
            r_res_lo     <= 8'd0;
            r_rsp_result <= 16'd0;
            r_rsp_flags  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_pass_done) begin
                        r_res_lo <= alu_result;
                        r_c_lo   <= alu_flags[3];
                        r_z_lo   <= alu_flags[1];
                        r_cnt    <= CNT_LOAD;
                        r_state  <= S_HI;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HI: begin
                    if (w_pass_done) begin
                        r_rsp_result <= {alu_result, r_res_lo};
                        // Z must cover both bytes, so merge with the low-pass zero flag.
                        r_rsp_flags  <= {alu_flags[3], alu_flags[2],
                                         r_z_lo & alu_flags[1], alu_flags[0]};
                        r_state      <= S_RSP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU drive mux: decodes registered state and operands only, so changes align to clk.
    always_comb begin
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        alu_op = 2'b00;
        case (r_state)
            S_LO: begin
                alu_a  = r_a[7:0];
                alu_b  = r_b[7:0];
                alu_op = {1'b0, r_op};
            end
            S_HI: begin
                alu_a  = r_a[15:8];
                alu_b  = r_b[15:8];
                alu_op = {r_c_lo, r_op};
            end
            default: begin
                alu_a  = 8'd0;
                alu_b  = 8'd0;
                alu_op = 2'b00;
            end
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RSP);
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: two instances (WAIT_CYCLES 0 and 2), each wired to a behavioural
// 8-bit ALU, checked against directed vectors and a 16-bit arithmetic reference model.
module tb_alu_wide_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_op     [2];
    logic [15:0] req_a      [2];
    logic [15:0] req_b      [2];
    logic [7:0]  alu_a      [2];
    logic [7:0]  alu_b      [2];
    logic [1:0]  alu_op     [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [15:0] rsp_result [2];
    logic [3:0]  rsp_flags  [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] ops_seen [16];
    int         n_ops;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [8:0] w_sum;
        int         w_sv;
        logic [7:0] w_res;
        logic [3:0] w_flags;

        // Behavioural 8-bit ALU: op[0] selects subtract, op[1] is the extra +1/-1.
        always_comb begin
            w_sum = 9'd0;
            w_sv  = 0;
            if (alu_op[g][0] == 1'b0) begin
                w_sum = {1'b0, alu_a[g]} + {1'b0, alu_b[g]} + {8'd0, alu_op[g][1]};
                w_sv  = int'($signed(alu_a[g])) + int'($signed(alu_b[g])) + int'(alu_op[g][1]);
            end else begin
                w_sum = {1'b0, alu_a[g]} - {1'b0, alu_b[g]} - {8'd0, alu_op[g][1]};
                w_sv  = int'($signed(alu_a[g])) - int'($signed(alu_b[g])) - int'(alu_op[g][1]);
            end
            w_res   = w_sum[7:0];
            w_flags = {w_sum[8], (w_sv > 127) || (w_sv < -128), w_sum[7:0] == 8'd0, w_sum[7]};
        end

        alu_wide_seq #(.WAIT_CYCLES((g == 0) ? 0 : 2)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_op     (req_op[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_op     (alu_op[g]),
            .alu_result (w_res),
            .alu_flags  (w_flags),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .rsp_flags  (rsp_flags[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 16-bit arithmetic, returns {result, C, V, Z, N}.
    function automatic logic [19:0] ref_model(input bit op, input logic [15:0] a, input logic [15:0] b);
        int         sa;
        int         sb;
        int         sr;
        logic [16:0] u;
        logic       c;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!op) begin
            u  = {1'b0, a} + {1'b0, b};
            sr = sa + sb;
            c  = u[16];
        end else begin
            u  = {1'b0, a} - {1'b0, b};
            sr = sa - sb;
            c  = (a < b);
        end
        return {u[15:0], c, (sr > 32767) || (sr < -32768), u[15:0] == 16'd0, u[15]};
    endfunction

    task automatic run_txn(input int k, input bit op, input logic [15:0] a, input logic [15:0] b,
                           input int hold, output logic [15:0] res, output logic [3:0] fl,
                           output int lat);
        int guard;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        req_a[k]     = a;
        req_b[k]     = b;
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_op[k]    = ~op;
        req_a[k]     = 16'($urandom);
        req_b[k]     = 16'($urandom);
        n_ops = 0;
        guard = 0;
        while (rsp_valid[k] !== 1'b1 && guard < 40) begin
            if (n_ops < 16) ops_seen[n_ops] = alu_op[k];
            n_ops++;
            guard++;
            @(negedge clk);
        end
        lat = guard + 1;
        res = rsp_result[k];
        fl  = rsp_flags[k];
        if (guard >= 40) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            chk("bp_valid", 32'(rsp_valid[k]), 32'd1);
            chk("bp_result", 32'(rsp_result[k]), 32'(res));
            chk("bp_flags", 32'(rsp_flags[k]), 32'(fl));
            chk("bp_req_ready", 32'(req_ready[k]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        chk("post_req_ready", 32'(req_ready[k]), 32'd1);
        chk("post_result_kept", 32'(rsp_result[k]), 32'(res));
    endtask

    typedef struct {
        bit          op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        logic [1:0]  lo_op;
        logic [1:0]  hi_op;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
        logic [19:0] exp;
        int          w;

        vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 2'b00, 2'b10};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 2'b00, 2'b10};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2'b00, 2'b10};
        vecs[3] = '{1'b1, 16'h0100, 16'h0001, 16'h00FF, 4'b0000, 2'b01, 2'b11};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b1001, 2'b01, 2'b11};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100, 2'b01, 2'b11};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b0010, 2'b01, 2'b01};
        vecs[7] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 4'b0000, 2'b00, 2'b00};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_op[k]    = 1'b0;
            req_a[k]     = 16'd0;
            req_b[k]     = 16'd0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_result", 32'(rsp_result[k]), 32'd0);
            chk("rst_rsp_flags", 32'(rsp_flags[k]), 32'd0);
            chk("rst_alu", 32'({alu_a[k], alu_b[k], alu_op[k]}), 32'd0);
        end
        rst_n = 1'b1;

        // rsp_ready with nothing pending must be harmless
        rsp_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rsp_ready_valid", 32'(rsp_valid[0]), 32'd0);
        chk("idle_rsp_ready_ready", 32'(req_ready[0]), 32'd1);
        rsp_ready[0] = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, 0, res, fl, lat);
            chk("vec_result", 32'(res), 32'(vecs[i].res));
            chk("vec_flags", 32'(fl), 32'(vecs[i].fl));
            chk("vec_latency", 32'(lat), 32'd3);
            chk("vec_lo_op", 32'(ops_seen[0]), 32'(vecs[i].lo_op));
            chk("vec_hi_op", 32'(ops_seen[1]), 32'(vecs[i].hi_op));
        end

        // Backpressure then an immediate follow-on request
        run_txn(0, vecs[3].op, vecs[3].a, vecs[3].b, 5, res, fl, lat);
        chk("bp_vec_result", 32'(res), 32'(vecs[3].res));
        run_txn(0, vecs[2].op, vecs[2].a, vecs[2].b, 0, res, fl, lat);
        chk("bp_next_result", 32'(res), 32'(vecs[2].res));
        chk("bp_next_flags", 32'(fl), 32'(vecs[2].fl));

        for (int i = 0; i < 24; i++) begin
            int          k;
            bit          op;
            logic [15:0] a;
            logic [15:0] b;
            logic [1:0]  hi_exp;
            k  = i % 2;
            w  = (k == 0) ? 0 : 2;
            op = 1'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 5 == 0) b = a;
            exp = ref_model(op, a, b);
            run_txn(k, op, a, b, int'($urandom_range(0, 2)), res, fl, lat);
            chk("rnd_result", 32'(res), 32'(exp[19:4]));
            chk("rnd_flags", 32'(fl), 32'(exp[3:0]));
            chk("rnd_latency", 32'(lat), 32'(2 * (w + 1) + 1));
            chk("rnd_n_ops", 32'(n_ops), 32'(2 * (w + 1)));
            if (op) hi_exp = {(a[7:0] < b[7:0]), 1'b1};
            else    hi_exp = {(9'(a[7:0]) + 9'(b[7:0]) > 9'd255), 1'b0};
            chk("rnd_lo_op_first", 32'(ops_seen[0]), 32'({1'b0, op}));
            chk("rnd_lo_op_last", 32'(ops_seen[w]), 32'({1'b0, op}));
            chk("rnd_hi_op_first", 32'(ops_seen[w + 1]), 32'(hi_exp));
            chk("rnd_hi_op_last", 32'(ops_seen[2 * w + 1]), 32'(hi_exp));
        end

        // Reset during the high pass of the WAIT_CYCLES=2 instance
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1]    = 1'b0;
        req_a[1]     = 16'hABCD;
        req_b[1]     = 16'h1111;
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_hi_alu_a", 32'(alu_a[1]), 32'h00AB);
        chk("mid_hi_alu_op", 32'(alu_op[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_alu", 32'({alu_a[1], alu_b[1], alu_op[1]}), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready[1]), 32'd1);
        chk("async_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("async_rst_rsp_result", 32'(rsp_result[1]), 32'd0);
        chk("async_rst_rsp_flags", 32'(rsp_flags[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
